// File: rtl/msg_sched_window.sv
`default_nettype none
// ============================================================================
// Module      : msg_sched_window
// Description : SHA-2 message scheduler using a 16-word sliding window.
//               Loads 16 block words and streams W[0..ROUNDS-1] downstream.
//               Optional abort port enabled by defining MSG_SCHED_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module msg_sched_window #(
    parameter int DATA_WIDTH = 32,
    parameter int ROUNDS     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic [6:0]            w_index,
    output logic                  w_last,
`ifdef MSG_SCHED_ABORT_EN
    input  logic                  abort_in,
`endif
    output logic                  done_out
);

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("msg_sched_window: DATA_WIDTH must be 32 or 64");
        end
        if (ROUNDS < 17 || ROUNDS > 128) begin : g_bad_rounds
            $error("msg_sched_window: ROUNDS out of range");
        end
    endgenerate

    // Rotation / shift amounts for sig0 and sig1 of the selected SHA-2 family
    localparam int c_S0_A = (DATA_WIDTH == 64) ? 1  : 7;
    localparam int c_S0_B = (DATA_WIDTH == 64) ? 8  : 18;
    localparam int c_S0_C = (DATA_WIDTH == 64) ? 7  : 3;
    localparam int c_S1_A = (DATA_WIDTH == 64) ? 19 : 17;
    localparam int c_S1_B = (DATA_WIDTH == 64) ? 61 : 19;
    localparam int c_S1_C = (DATA_WIDTH == 64) ? 6  : 10;

    localparam logic [6:0] c_LAST   = 7'(ROUNDS - 1);
    localparam logic [6:0] c_PENULT = 7'(ROUNDS - 2);
    localparam logic [3:0] c_LOAD_LAST = 4'd15;

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_win [16];
    logic [3:0]            r_load_cnt;
    logic [6:0]            r_idx;
    logic                  r_last;
    logic                  r_done;

    logic                  w_abort;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_final;
    logic [DATA_WIDTH-1:0] w_sig0;
    logic [DATA_WIDTH-1:0] w_sig1;
    logic [DATA_WIDTH-1:0] w_new;

`ifdef MSG_SCHED_ABORT_EN
    assign w_abort = abort_in;
`else
    assign w_abort = 1'b0;
`endif

    function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x,
                                                   input int n);
        return (x >> n) | (x << (DATA_WIDTH - n));
    endfunction

    // Window holds W[t-16..t-1]: win[14]=W[t-2], win[9]=W[t-7], win[1]=W[t-15]
    assign w_sig0 = rotr(r_win[1], c_S0_A) ^ rotr(r_win[1], c_S0_B) ^ (r_win[1] >> c_S0_C);
    assign w_sig1 = rotr(r_win[14], c_S1_A) ^ rotr(r_win[14], c_S1_B) ^ (r_win[14] >> c_S1_C);
    assign w_new  = w_sig1 + r_win[9] + w_sig0 + r_win[0];

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = w_valid & w_ready;
    assign w_final    = w_out_fire && (r_idx == c_LAST);

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (r_load_cnt == c_LOAD_LAST)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_valid = 1'b1;
                if (w_ready && (r_idx == c_LAST)) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
        if (w_abort) begin
            w_state_nxt = S_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_LOAD;
            r_load_cnt <= '0;
            r_idx      <= '0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_final && !w_abort;
            if (w_abort) begin
                // Abort wins over a coincident handshake; the window is left as-is
                r_load_cnt <= '0;
                r_idx      <= '0;
                r_last     <= 1'b0;
            end else if (w_in_fire) begin
                for (int i = 0; i < 15; i++) begin
                    r_win[i] <= r_win[i+1];
                end
                r_win[15]  <= in_data;
                r_load_cnt <= r_load_cnt + 4'd1;
                if (r_load_cnt == c_LOAD_LAST) begin
                    r_idx  <= '0;
                    r_last <= 1'b0;
                end
            end else if (w_out_fire) begin
                for (int i = 0; i < 15; i++) begin
                    r_win[i] <= r_win[i+1];
                end
                r_win[15] <= w_new;
                if (w_final) begin
                    r_load_cnt <= '0;
                    r_idx      <= '0;
                    r_last     <= 1'b0;
                end else begin
                    r_idx  <= r_idx + 7'd1;
                    r_last <= (r_idx == c_PENULT);
                end
            end
        end
    end

    assign w_data   = r_win[0];
    assign w_index  = r_idx;
    assign w_last   = r_last;
    assign done_out = r_done;

endmodule
`default_nettype wire

// File: tb/tb_msg_sched_window.sv
`default_nettype none
// ============================================================================
// Module      : tb_msg_sched_window
// Description : Directed bench for msg_sched_window, 32- and 64-bit instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msg_sched_window;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        in_valid;
    logic        w_ready;
    logic [63:0] in_data;
`ifdef MSG_SCHED_ABORT_EN
    logic        abort_in;
`endif

    logic        in_valid32, in_valid64;
    logic        in_ready32, in_ready64;
    logic        w_valid32, w_valid64;
    logic [31:0] w_data32;
    logic [63:0] w_data64;
    logic [6:0]  w_index32, w_index64;
    logic        w_last32, w_last64;
    logic        done32, done64;

    logic        cur_in_ready, cur_valid, cur_last, cur_done;
    logic [63:0] cur_data;
    logic [6:0]  cur_index;

    always #5 clk = ~clk;

    assign in_valid32   = in_valid & ~sel;
    assign in_valid64   = in_valid & sel;
    assign cur_in_ready = sel ? in_ready64 : in_ready32;
    assign cur_valid    = sel ? w_valid64  : w_valid32;
    assign cur_data     = sel ? w_data64   : {32'h0, w_data32};
    assign cur_index    = sel ? w_index64  : w_index32;
    assign cur_last     = sel ? w_last64   : w_last32;
    assign cur_done     = sel ? done64     : done32;

    msg_sched_window #(.DATA_WIDTH(32), .ROUNDS(64)) u_dut32 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid32),
        .in_ready (in_ready32),
        .in_data  (in_data[31:0]),
        .w_valid  (w_valid32),
        .w_ready  (w_ready),
        .w_data   (w_data32),
        .w_index  (w_index32),
        .w_last   (w_last32),
`ifdef MSG_SCHED_ABORT_EN
        .abort_in (abort_in),
`endif
        .done_out (done32)
    );

    msg_sched_window #(.DATA_WIDTH(64), .ROUNDS(80)) u_dut64 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid64),
        .in_ready (in_ready64),
        .in_data  (in_data),
        .w_valid  (w_valid64),
        .w_ready  (w_ready),
        .w_data   (w_data64),
        .w_index  (w_index64),
        .w_last   (w_last64),
`ifdef MSG_SCHED_ABORT_EN
        .abort_in (abort_in),
`endif
        .done_out (done64)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] blk [16];
    logic [63:0] nxt [16];
    logic [63:0] m [80];
    logic [63:0] got_d [80];
    int          got_i [80];
    logic        got_l [80];
    int          got_cnt, drain_cyc, done_early, ready_bad, hold_bad;
    bit          cut_hit, timed_out;
    logic        done_seen, ready_after, valid_after;

    function automatic int nr();
        return sel ? 80 : 64;
    endfunction

    function automatic logic [63:0] rr(input logic [63:0] x, input int n);
        logic [31:0] y;
        y = x[31:0];
        if (sel) return (x >> n) | (x << (64 - n));
        return {32'h0, (y >> n) | (y << (32 - n))};
    endfunction

    function automatic logic [63:0] s0(input logic [63:0] x);
        if (sel) return rr(x, 1) ^ rr(x, 8) ^ (x >> 7);
        return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [63:0] s1(input logic [63:0] x);
        if (sel) return rr(x, 19) ^ rr(x, 61) ^ (x >> 6);
        return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
    endfunction

    // Reference schedule in the textbook full-array form
    task automatic build_model();
        for (int t = 0; t < 16; t++) m[t] = sel ? blk[t] : {32'h0, blk[t][31:0]};
        for (int t = 16; t < nr(); t++) begin
            m[t] = s1(m[t-2]) + m[t-7] + s0(m[t-15]) + m[t-16];
            if (!sel) m[t][63:32] = 32'h0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic abc_block();
        for (int i = 0; i < 16; i++) blk[i] = 64'h0;
        blk[0]  = sel ? 64'h6162638000000000 : 64'h0000000061626380;
        blk[15] = 64'h18;
    endtask

    task automatic rand_block();
        for (int i = 0; i < 16; i++) blk[i] = {$urandom, $urandom};
    endtask

    task automatic load_block(input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            in_valid = 1'b1;
            in_data  = sel ? blk[i] : {32'h0, blk[i][31:0]};
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Collects output beats; stalls w_ready at stall_at, stops early at cut_at
    task automatic drain(input int stall_at, input int stall_len, input int cut_at);
        int st;
        logic [63:0] hd;
        int hi;
        for (int i = 0; i < 80; i++) begin
            got_d[i] = 'x;
            got_i[i] = -1;
            got_l[i] = 1'bx;
        end
        got_cnt = 0; drain_cyc = 0; done_early = 0; ready_bad = 0; hold_bad = 0;
        cut_hit = 0; timed_out = 0; st = 0; hd = '0; hi = 0;
        w_ready = 1'b1;
        while (got_cnt < nr()) begin
            if (drain_cyc >= 400) begin
                timed_out = 1;
                break;
            end
            if (cut_at >= 0 && cur_valid && int'(cur_index) == cut_at) begin
                cut_hit = 1;
                break;
            end
            if (cur_done) done_early++;
            if (cur_valid && cur_in_ready) ready_bad++;
            if (cur_valid && int'(cur_index) == stall_at && st < stall_len) begin
                if (st > 0 && (cur_data !== hd || int'(cur_index) !== hi)) hold_bad++;
                hd = cur_data;
                hi = int'(cur_index);
                w_ready = 1'b0;
                st++;
            end else begin
                w_ready = 1'b1;
            end
            if (cur_valid && w_ready) begin
                got_d[got_cnt] = cur_data;
                got_i[got_cnt] = int'(cur_index);
                got_l[got_cnt] = cur_last;
                got_cnt++;
            end
            tick();
            drain_cyc++;
        end
        done_seen   = cur_done;
        ready_after = cur_in_ready;
        valid_after = cur_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; sel = 1'b0; in_valid = 1'b0; w_ready = 1'b0; in_data = '0;
`ifdef MSG_SCHED_ABORT_EN
        abort_in = 1'b0;
`endif
        repeat (2) tick();
        n_cmp++; if (in_ready32 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready32: got %b want 1", in_ready32); end
        n_cmp++; if (w_valid32 !== 1'b0) begin n_err++; $display("FAIL reset_w_valid32: got %b want 0", w_valid32); end
        n_cmp++; if (w_last32 !== 1'b0) begin n_err++; $display("FAIL reset_w_last32: got %b want 0", w_last32); end
        n_cmp++; if (done32 !== 1'b0) begin n_err++; $display("FAIL reset_done32: got %b want 0", done32); end
        n_cmp++; if (w_index32 !== 7'd0) begin n_err++; $display("FAIL reset_w_index32: got %0d want 0", w_index32); end
        n_cmp++; if (w_data32 !== 32'h0) begin n_err++; $display("FAIL reset_w_data32: got %h want 0", w_data32); end
        n_cmp++; if (in_ready64 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready64: got %b want 1", in_ready64); end
        n_cmp++; if (w_valid64 !== 1'b0) begin n_err++; $display("FAIL reset_w_valid64: got %b want 0", w_valid64); end
        n_cmp++; if (w_data64 !== 64'h0) begin n_err++; $display("FAIL reset_w_data64: got %h want 0", w_data64); end
        rst = 1'b0;
    endtask

    task automatic test_abc(input bit wide);
        sel = wide;
        abc_block();
        build_model();
        load_block(1'b0);
        n_cmp++; if (cur_valid !== 1'b1 || cur_index !== 7'd0) begin n_err++; $display("FAIL abc%0d_latency: valid %b idx %0d want 1 idx 0", wide, cur_valid, cur_index); end
        drain(-1, 0, -1);
        n_cmp++; if (timed_out || drain_cyc !== nr()) begin n_err++; $display("FAIL abc%0d_cycles: got %0d want %0d", wide, drain_cyc, nr()); end
        for (int i = 0; i < nr(); i++) begin
            n_cmp++;
            if (got_d[i] !== m[i] || got_i[i] !== i || got_l[i] !== (i == nr() - 1)) begin
                n_err++;
                $display("FAIL abc%0d_word[%0d]: got %h idx %0d last %b want %h idx %0d", wide, i, got_d[i], got_i[i], got_l[i], m[i], i);
            end
        end
        n_cmp++; if (got_d[0] !== (wide ? 64'h6162638000000000 : 64'h61626380)) begin n_err++; $display("FAIL abc%0d_w0: got %h", wide, got_d[0]); end
        n_cmp++; if (got_d[15] !== 64'h18) begin n_err++; $display("FAIL abc%0d_w15: got %h want 18", wide, got_d[15]); end
        n_cmp++; if (got_d[16] !== (wide ? 64'h6162638000000000 : 64'h61626380)) begin n_err++; $display("FAIL abc%0d_w16: got %h", wide, got_d[16]); end
        n_cmp++; if (got_d[17] !== (wide ? 64'h00030000000000C0 : 64'h000F0000)) begin n_err++; $display("FAIL abc%0d_w17: got %h", wide, got_d[17]); end
        n_cmp++; if (done_early !== 0 || done_seen !== 1'b1) begin n_err++; $display("FAIL abc%0d_done: early %0d after %b want 0 and 1", wide, done_early, done_seen); end
        n_cmp++; if (ready_after !== 1'b1 || valid_after !== 1'b0) begin n_err++; $display("FAIL abc%0d_reload: in_ready %b w_valid %b want 1 0", wide, ready_after, valid_after); end
        tick();
        n_cmp++; if (cur_done !== 1'b0) begin n_err++; $display("FAIL abc%0d_done_width: got %b want 0", wide, cur_done); end
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        rand_block();
        build_model();
        load_block(1'b0);
        drain(20, 5, -1);
        n_cmp++; if (timed_out || drain_cyc !== 69) begin n_err++; $display("FAIL bp_cycles: got %0d want 69", drain_cyc); end
        n_cmp++; if (hold_bad !== 0) begin n_err++; $display("FAIL bp_hold: got %0d changes want 0", hold_bad); end
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (got_d[i] !== m[i] || got_i[i] !== i) begin
                n_err++;
                $display("FAIL bp_word[%0d]: got %h idx %0d want %h idx %0d", i, got_d[i], got_i[i], m[i], i);
            end
        end
        n_cmp++; if (done_seen !== 1'b1) begin n_err++; $display("FAIL bp_done: got %b want 1", done_seen); end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        rand_block();
        for (int i = 0; i < 16; i++) nxt[i] = {$urandom, $urandom};
        build_model();
        load_block(1'b1);
        in_valid = 1'b1;
        in_data  = {32'h0, nxt[0][31:0]};
        drain(-1, 0, -1);
        n_cmp++; if (ready_bad !== 0) begin n_err++; $display("FAIL b2b_in_ready_run: got %0d cycles want 0", ready_bad); end
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (got_d[i] !== m[i] || got_i[i] !== i) begin
                n_err++;
                $display("FAIL b2b_a_word[%0d]: got %h want %h", i, got_d[i], m[i]);
            end
        end
        for (int i = 0; i < 16; i++) blk[i] = nxt[i];
        build_model();
        load_block(1'b0);
        drain(-1, 0, -1);
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (got_d[i] !== m[i] || got_i[i] !== i) begin
                n_err++;
                $display("FAIL b2b_b_word[%0d]: got %h want %h", i, got_d[i], m[i]);
            end
        end
    endtask

    task automatic test_rst_mid_run();
        sel = 1'b0;
        rand_block();
        build_model();
        load_block(1'b0);
        drain(-1, 0, 30);
        n_cmp++; if (cut_hit !== 1'b1) begin n_err++; $display("FAIL rst_reach30: got %b want 1", cut_hit); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (w_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin n_err++; $display("FAIL rst_state: w_valid %b in_ready %b want 0 1", w_valid32, in_ready32); end
        n_cmp++; if (w_index32 !== 7'd0 || w_data32 !== 32'h0 || done32 !== 1'b0) begin n_err++; $display("FAIL rst_regs: idx %0d data %h done %b want 0 0 0", w_index32, w_data32, done32); end
        rand_block();
        build_model();
        load_block(1'b0);
        drain(-1, 0, -1);
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (got_d[i] !== m[i] || got_i[i] !== i) begin
                n_err++;
                $display("FAIL rst_next_word[%0d]: got %h want %h", i, got_d[i], m[i]);
            end
        end
    endtask

`ifdef MSG_SCHED_ABORT_EN
    task automatic test_abort();
        logic [63:0] w10;
        sel = 1'b0;
        rand_block();
        build_model();
        w10 = m[10];
        load_block(1'b0);
        drain(-1, 0, 10);
        n_cmp++; if (cut_hit !== 1'b1) begin n_err++; $display("FAIL abort_reach10: got %b want 1", cut_hit); end
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        n_cmp++; if (w_valid32 !== 1'b0 || in_ready32 !== 1'b1 || done32 !== 1'b0) begin n_err++; $display("FAIL abort_state: w_valid %b in_ready %b done %b want 0 1 0", w_valid32, in_ready32, done32); end
        n_cmp++; if (w_index32 !== 7'd0 || {32'h0, w_data32} !== w10) begin n_err++; $display("FAIL abort_regs: idx %0d data %h want 0 %h", w_index32, w_data32, w10); end
        tick();
        n_cmp++; if (done32 !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got %b want 0", done32); end
        rand_block();
        build_model();
        load_block(1'b0);
        drain(-1, 0, -1);
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (got_d[i] !== m[i] || got_i[i] !== i) begin
                n_err++;
                $display("FAIL abort_next_word[%0d]: got %h want %h", i, got_d[i], m[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_abc(1'b0);
        test_abc(1'b1);
        test_backpressure();
        test_back_to_back();
        test_rst_mid_run();
`ifdef MSG_SCHED_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/msg_sched_window.md
# msg_sched_window

Parametrised SHA-2 message scheduler: accepts one 512/1024-bit block as 16 words over a valid/ready input stream and emits the full expanded schedule W[0..ROUNDS-1] as a backpressurable valid/ready output stream, one word per accepted beat. It sits between the block-padding front end and the compression round engine. A 16-entry sliding window replaces a full ROUNDS-deep array, so storage is fixed at 16 words for both SHA-256 and SHA-512.

## Interface
- DATA_WIDTH, 32: word width; legal values are 32 (SHA-224/256) and 64 (SHA-384/512). Any other value is an elaboration error.
- ROUNDS, 64: schedule length; 64 for DATA_WIDTH=32, 80 for DATA_WIDTH=64.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  scheduler accepts an input word.
- in_data  in  DATA_WIDTH  message word, big-endian word order W0 first.
- w_valid  out  1  schedule word valid.
- w_ready  in  1  consumer accepts the schedule word.
- w_data  out  DATA_WIDTH  schedule word W[w_index].
- w_index  out  7  round index of w_data, 0..ROUNDS-1.
- w_last  out  1  high with w_valid when w_index == ROUNDS-1.
- done_out  out  1  one-cycle pulse after the last word handshake.
- abort_in  in  1  only with MSG_SCHED_ABORT_EN; see Configuration.

## Operation
- States: LOAD, RUN. Reset state LOAD.
- LOAD: in_ready=1, w_valid=0. Each in_valid&&in_ready beat shifts window down (win[i] <= win[i+1]) and writes win[15] <= in_data; load counter increments. On the 16th beat, go to RUN, clear w_index to 0.
- RUN: in_ready=0, w_valid=1, w_data=win[0], w_index=round counter. Window holds W[t-16..t-1] relative to the next word to compute.
- On w_valid&&w_ready in RUN: shift window down; win[15] <= sig1(win[14]) + win[9] + sig0(win[1]) + win[0], modulo 2^DATA_WIDTH; w_index increments.
- Words 0..15 exit unmodified (the loaded block); words 16..ROUNDS-1 are expanded. New-word computation continues past round ROUNDS-16 harmlessly; those values are never emitted.
- DATA_WIDTH=32: sig0 = ROTR7^ROTR18^SHR3, sig1 = ROTR17^ROTR19^SHR10.
- DATA_WIDTH=64: sig0 = ROTR1^ROTR8^SHR7, sig1 = ROTR19^ROTR61^SHR6.
- Handshake on w_index == ROUNDS-1: go to LOAD, load counter to 0, done_out=1 for the following cycle. Window contents are not cleared.
- in_valid while in RUN is ignored (in_ready=0); data must be held by the source.
- w_ready with w_valid low has no effect.

## Timing
- Reset (rst high at clk edge): state LOAD, load counter 0, w_index 0, all window words 0, w_valid 0, w_last 0, done_out 0, in_ready 1 from the next cycle. Reset mid-RUN or mid-LOAD discards the block entirely.
- Sustained throughput: 1 input word/cycle in LOAD, 1 schedule word/cycle in RUN with w_ready held high.
- Latency: w_valid rises the cycle after the 16th input handshake; first word is W0.
- Block period with no stalls: 16 + ROUNDS cycles; LOAD resumes the cycle after the last output handshake (in_ready=1 there, done_out=1 same cycle).
- w_data, w_index, w_last are register outputs; stable while w_valid && !w_ready (AXI-style hold).
- in_ready and w_valid depend only on state, never combinationally on in_valid/w_ready.

## Configuration
- MSG_SCHED_ABORT_EN defined: port abort_in present. abort_in high at a clk edge (rst low) forces state LOAD, load counter 0, w_index 0, w_valid 0 next cycle; no done_out pulse; window not cleared. abort_in has priority over any simultaneous handshake; rst has priority over abort_in.
- Not defined: port absent; a block can only be cancelled by rst.

## Test plan
- DATA_WIDTH=32, load SHA-256 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> 64 beats, W0=0x61626380, W15=0x18, W16=0x61626380, W17=0x000F0000, w_last only at index 63, done_out one cycle after.
- DATA_WIDTH=64, ROUNDS=80, SHA-512 "abc" block (W0=0x6162638000000000, W15=0x18) -> W16=0x6162638000000000, W17=0x00030000000000C0, 80 beats, w_last at 79.
- Drop w_ready for 5 cycles at w_index=20 -> w_data/w_index frozen, no word lost or duplicated; full sequence matches software model.
- Random in_valid gaps during LOAD and in_valid held high during RUN -> in_ready=0 in RUN, exactly 16 words consumed per block, back-to-back blocks both correct.
- Assert rst at w_index=30 -> next cycle w_valid=0, in_ready=1; following block output fully correct.
- With MSG_SCHED_ABORT_EN: abort_in at w_index=10 concurrent with handshake -> LOAD next cycle, no done_out, next block correct.
